max_unpooling_layer: RTL and testbench

- Streaming 2x2 stride-2 max-unpooling block; the inverse of the layer-1 max pooling stage.
- Consumes pooled pixels (14x14 per channel, channel-major, raster order), each with a 2-bit argmax index.
- Emits a 28x28-per-channel raster stream with each value placed at its argmax position and zeros elsewhere.
- Sits on the decoder/visualisation path after pooling; valid/ready on both sides.

---
 rtl/max_unpooling_layer.sv | 203 ++++++++++++++++++++
 tb/tb_max_unpooling_layer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpooling_layer.sv
// Streaming 2x2 stride-2 max-unpooling: places each pooled value at its argmax
// position in a 28x28 raster per channel. Define UNPOOL_NEAREST_EN for nearest-neighbour upsampling.
module max_unpooling_layer #(
   parameter int INPUT_CHANNELS   = 4,
   parameter int FEATURE_BITWIDTH = 8,
   parameter int POOLED_WIDTH     = 14,
   parameter int POOLED_HEIGHT    = 14,
   parameter int OUTPUT_WIDTH     = 2 * POOLED_WIDTH,
   parameter int OUTPUT_HEIGHT    = 2 * POOLED_HEIGHT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        soft_rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [FEATURE_BITWIDTH-1:0] in_data,
   input  logic [1:0]                  in_idx,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [FEATURE_BITWIDTH-1:0] out_data,
   output logic                        out_last
);

   localparam int PX_W = $clog2(OUTPUT_WIDTH);
   localparam int PY_W = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1;
   localparam int CH_W = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
   localparam logic [PX_W-1:0] PX_MAX = PX_W'(OUTPUT_WIDTH - 1);
   localparam logic [PY_W-1:0] PY_MAX = PY_W'(OUTPUT_HEIGHT / 2 - 1);
   localparam logic [CH_W-1:0] CH_MAX = CH_W'(INPUT_CHANNELS - 1);

   typedef enum logic [1:0] {
      TOP_FETCH = 2'd0,
      TOP_ODD   = 2'd1,
      BOT       = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [PX_W-1:0]             px_q, px_d;
   logic [PY_W-1:0]             py_q, py_d;
   logic [CH_W-1:0]             ch_q, ch_d;
   logic [FEATURE_BITWIDTH-1:0] hold_val_q, hold_val_d;
   logic [1:0]                  hold_idx_q, hold_idx_d;
   logic                        out_valid_q, out_valid_d;
   logic [FEATURE_BITWIDTH-1:0] out_data_q, out_data_d;
   logic                        out_last_q, out_last_d;

   logic [FEATURE_BITWIDTH+1:0] line_buf_q [POOLED_WIDTH];
   logic [PX_W-2:0]             buf_addr_s;
   logic [FEATURE_BITWIDTH+1:0] buf_rd_s;
   logic                        buf_we_s;
   logic                        load_en_s;
   logic                        in_ready_s;

   // Value seen at window position pos given the stored argmax index.
   function automatic logic [FEATURE_BITWIDTH-1:0] place(
      input logic [FEATURE_BITWIDTH-1:0] val,
      input logic [1:0]                  idx,
      input logic [1:0]                  pos
   );
`ifdef UNPOOL_NEAREST_EN
      place = (idx == pos || 1'b1) ? val : {FEATURE_BITWIDTH{1'b0}};
`else
      if (idx == pos) begin
         place = val;
      end else begin
         place = {FEATURE_BITWIDTH{1'b0}};
      end
`endif
   endfunction

   assign buf_addr_s = px_q[PX_W-1:1];
   assign buf_rd_s   = line_buf_q[buf_addr_s];
   assign load_en_s  = !out_valid_q || out_ready;
   assign in_ready_s = (state_q == TOP_FETCH) && load_en_s;

   // Next-state, counter and output-register computation.
   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      py_d        = py_q;
      ch_d        = ch_q;
      hold_val_d  = hold_val_q;
      hold_idx_d  = hold_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      buf_we_s    = 1'b0;

      // A firing pixel leaves the register unless a new one replaces it below.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      case (state_q)
         TOP_FETCH: begin
            if (in_valid && in_ready_s) begin
               hold_val_d  = in_data;
               hold_idx_d  = in_idx;
               buf_we_s    = 1'b1;
               out_valid_d = 1'b1;
               out_data_d  = place(in_data, in_idx, 2'd0);
               out_last_d  = 1'b0;
               px_d        = px_q + PX_W'(1);
               state_d     = TOP_ODD;
            end else begin
               state_d = TOP_FETCH;
            end
         end
         TOP_ODD: begin
            if (load_en_s) begin
               out_valid_d = 1'b1;
               out_data_d  = place(hold_val_q, hold_idx_q, 2'd1);
               out_last_d  = 1'b0;
               if (px_q == PX_MAX) begin
                  px_d    = {PX_W{1'b0}};
                  state_d = BOT;
               end else begin
                  px_d    = px_q + PX_W'(1);
                  state_d = TOP_FETCH;
               end
            end else begin
               state_d = TOP_ODD;
            end
         end
         BOT: begin
            if (load_en_s) begin
               out_valid_d = 1'b1;
               out_data_d  = place(buf_rd_s[FEATURE_BITWIDTH+1:2], buf_rd_s[1:0],
                                   px_q[0] ? 2'd3 : 2'd2);
               out_last_d  = (px_q == PX_MAX) && (py_q == PY_MAX) && (ch_q == CH_MAX);
               if (px_q == PX_MAX) begin
                  px_d    = {PX_W{1'b0}};
                  state_d = TOP_FETCH;
                  if (py_q == PY_MAX) begin
                     py_d = {PY_W{1'b0}};
                     ch_d = (ch_q == CH_MAX) ? {CH_W{1'b0}} : ch_q + CH_W'(1);
                  end else begin
                     py_d = py_q + PY_W'(1);
                  end
               end else begin
                  px_d    = px_q + PX_W'(1);
                  state_d = BOT;
               end
            end else begin
               state_d = BOT;
            end
         end
         default: begin
            state_d = TOP_FETCH;
         end
      endcase
   end

   // State, counters and output register with async and synchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= TOP_FETCH;
         px_q        <= {PX_W{1'b0}};
         py_q        <= {PY_W{1'b0}};
         ch_q        <= {CH_W{1'b0}};
         hold_val_q  <= {FEATURE_BITWIDTH{1'b0}};
         hold_idx_q  <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= {FEATURE_BITWIDTH{1'b0}};
         out_last_q  <= 1'b0;
      end else if (soft_rst) begin
         state_q     <= TOP_FETCH;
         px_q        <= {PX_W{1'b0}};
         py_q        <= {PY_W{1'b0}};
         ch_q        <= {CH_W{1'b0}};
         hold_val_q  <= {FEATURE_BITWIDTH{1'b0}};
         hold_idx_q  <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= {FEATURE_BITWIDTH{1'b0}};
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         py_q        <= py_d;
         ch_q        <= ch_d;
         hold_val_q  <= hold_val_d;
         hold_idx_q  <= hold_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Top-row line buffer; contents need no reset.
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         line_buf_q[buf_addr_s] <= {in_data, in_idx};
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_max_unpooling_layer.sv
// Scoreboard bench for max_unpooling_layer: a row-based golden model pushes
// expected pixels on each accepted input; outputs are popped and compared as they fire.
module tb_max_unpooling_layer;

   localparam int CH    = 4;
   localparam int PW    = 14;
   localparam int PH    = 14;
   localparam int OW    = 28;
   localparam int NIN   = CH * PW * PH;
   localparam int NOUT  = 4 * NIN;
   localparam int LIMIT = 20000;

   logic       clk, rst_n, soft_rst;
   logic       in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0] in_data, out_data;
   logic [1:0] in_idx;

   max_unpooling_layer dut (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0] frame_d [NIN];
   logic [9:0] stim_q [$];
   logic [8:0] exp_q [$];
   int         rec_q [$];
   int         clean_q [$];
   logic [9:0] m_row [PW];
   int  m_x, m_y, m_ch;
   int  n_out, n_acc, last_cnt, last_at, nz_cnt, cnt_7f, zero_run, max_zero_run;
   bit  bp_en, rec_en, hold_pending;
   logic [7:0] hold_val;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_px(input logic [7:0] v, input logic [1:0] i, input logic [1:0] p);
`ifdef UNPOOL_NEAREST_EN
      return v;
`else
      return (i == p) ? v : 8'h00;
`endif
   endfunction

   task automatic model_accept(input logic [9:0] s);
      logic [9:0] r;
      logic       lst;
      exp_q.push_back({1'b0, exp_px(s[9:2], s[1:0], 2'd0)});
      exp_q.push_back({1'b0, exp_px(s[9:2], s[1:0], 2'd1)});
      m_row[m_x] = s;
      m_x++;
      if (m_x == PW) begin
         m_x = 0;
         for (int ox = 0; ox < OW; ox++) begin
            r   = m_row[ox / 2];
            lst = (ox == OW - 1) && (m_y == PH - 1) && (m_ch == CH - 1);
            exp_q.push_back({lst, exp_px(r[9:2], r[1:0], (ox % 2 == 1) ? 2'd3 : 2'd2)});
         end
         m_y++;
         if (m_y == PH) begin
            m_y  = 0;
            m_ch = (m_ch + 1) % CH;
         end
      end
   endtask

   task automatic clear_model();
      stim_q.delete();
      exp_q.delete();
      m_x = 0; m_y = 0; m_ch = 0;
      hold_pending = 1'b0;
      zero_run = 0;
   endtask

   task automatic run_cycle();
      logic [8:0] e;
      @(negedge clk);
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stim_q.size() > 0) begin
         in_valid = 1'b1;
         {in_data, in_idx} = stim_q[0];
      end else begin
         in_valid = 1'b0;
      end
      #1;
      if (hold_pending) begin
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_data", out_data, hold_val);
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_data", out_data, e[7:0]);
            check_eq("out_last", out_last, e[8]);
         end
         if (out_last) begin
            last_cnt++;
            last_at = n_out;
         end
         if (out_data != 8'h00) nz_cnt++;
         if (out_data == 8'h7F) cnt_7f++;
         if (rec_en) rec_q.push_back(int'(out_data));
      end
      if (in_ready) begin
         zero_run = 0;
      end else begin
         zero_run++;
         if (zero_run > max_zero_run) max_zero_run = zero_run;
      end
      if (in_valid && in_ready) begin
         n_acc++;
         model_accept(stim_q.pop_front());
      end
      hold_pending = out_valid && !out_ready;
      hold_val     = out_data;
   endtask

   task automatic drain();
      int budget = 0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && budget < LIMIT) begin
         run_cycle();
         budget++;
      end
      check_eq("drain_timeout", budget >= LIMIT, 0);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_out_valid"}, out_valid, 0);
      check_eq({tag, "_out_data"}, out_data, 0);
      check_eq({tag, "_in_ready"}, in_ready, 1);
   endtask

   task automatic hard_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; soft_rst = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle(tag);
      clear_model();
   endtask

   task automatic load_frame();
      for (int i = 0; i < NIN; i++) stim_q.push_back(frame_d[i]);
   endtask

   task automatic compare_to_clean(input string tag);
      int mism = 0;
      check_eq({tag, "_len"}, rec_q.size(), clean_q.size());
      for (int i = 0; i < rec_q.size() && i < clean_q.size(); i++)
         if (rec_q[i] != clean_q[i]) mism++;
      check_eq({tag, "_seq"}, mism, 0);
   endtask

   initial begin
      rst_n = 1'b0; soft_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = 8'h00; in_idx = 2'd0;
      bp_en = 1'b0; rec_en = 1'b0;
      n_out = 0; n_acc = 0; last_cnt = 0; last_at = 0; nz_cnt = 0; cnt_7f = 0;
      max_zero_run = 0;
      for (int i = 0; i < NIN; i++) frame_d[i] = 10'($urandom);
      clear_model();

      hard_reset("reset");

      // Reset in the middle of a stalled, partially consumed frame.
      load_frame();
      bp_en = 1'b1;
      repeat (150) run_cycle();
      bp_en = 1'b0;
      hard_reset("midreset");

      // Single pooled row: x0 carries 0x5A at the top-right position.
      stim_q.push_back({8'h5A, 2'd1});
      for (int i = 1; i < PW; i++) stim_q.push_back({8'h00, 2'd0});
      max_zero_run = 0;
      drain();
      repeat (40) run_cycle();
      check_eq("row_ready_low_run", max_zero_run, 29);
      hard_reset("row_reset");

      // One pixel per argmax position.
      for (int i = 0; i < 4; i++) stim_q.push_back({8'(8'h11 + i), 2'(i)});
      for (int i = 4; i < PW; i++) stim_q.push_back({8'h00, 2'd0});
      nz_cnt = 0;
      drain();
`ifdef UNPOOL_NEAREST_EN
      check_eq("idx_nonzero", nz_cnt, 16);
`else
      check_eq("idx_nonzero", nz_cnt, 4);
`endif
      hard_reset("idx_reset");

      // Clean full frame.
      load_frame();
      n_out = 0; last_cnt = 0; last_at = 0;
      rec_q.delete(); rec_en = 1'b1;
      drain();
      rec_en = 1'b0;
      clean_q = rec_q;
      check_eq("frame_outputs", n_out, NOUT);
      check_eq("frame_last_cnt", last_cnt, 1);
      check_eq("frame_last_pos", last_at, NOUT);
      hard_reset("frame_reset");

      // Same frame under random backpressure.
      load_frame();
      rec_q.delete(); rec_en = 1'b1; bp_en = 1'b1;
      drain();
      rec_en = 1'b0; bp_en = 1'b0;
      compare_to_clean("bp");

      // soft_rst after 100 accepted inputs, then a full frame.
      hard_reset("pre_soft");
      load_frame();
      n_acc = 0;
      for (int b = 0; b < LIMIT && n_acc < 100; b++) run_cycle();
      check_eq("soft_pre_acc", n_acc, 100);
      @(negedge clk);
      soft_rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      soft_rst = 1'b0;
      #1;
      check_idle("soft");
      clear_model();
      load_frame();
      n_out = 0; last_cnt = 0;
      rec_q.delete(); rec_en = 1'b1;
      drain();
      rec_en = 1'b0;
      compare_to_clean("soft");
      check_eq("soft_last_cnt", last_cnt, 1);

`ifdef UNPOOL_NEAREST_EN
      hard_reset("near_reset");
      stim_q.push_back({8'h7F, 2'd2});
      for (int i = 1; i < PW; i++) stim_q.push_back({8'h00, 2'd0});
      cnt_7f = 0;
      drain();
      check_eq("nearest_7f", cnt_7f, 4);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
